// File: rtl/cpu_sequencer_if.sv
// Control bus between the multi-cycle sequencer and the core datapath
// (instruction memory, decoder, ALU, data memory, register file).
interface cpu_sequencer_if #(
  parameter int unsigned PC_W = 6
);
  logic            run;
  logic [1:0]      flag;
  logic [3:0]      oper;
  logic [1:0]      mem_op;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] pc;
  logic            fetch_en;
  logic            alu_en;
  logic            mem_we;
  logic            rf_we;
  logic            rf_waddr_sel;
  logic [1:0]      rf_wsrc;
  logic            opb_imm;
  logic            busy;
  logic            halted;
  logic            retired;
  logic            illegal;

  modport master (
    input  run, flag, oper, mem_op, jmp_tgt,
    output pc, fetch_en, alu_en, mem_we, rf_we, rf_waddr_sel, rf_wsrc,
           opb_imm, busy, halted, retired, illegal
  );

  modport slave (
    output run, flag, oper, mem_op, jmp_tgt,
    input  pc, fetch_en, alu_en, mem_we, rf_we, rf_waddr_sel, rf_wsrc,
           opb_imm, busy, halted, retired, illegal
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/ALUW/MEM/WB control FSM owning the program counter.
// All outputs are registered; each strobe is high for exactly one cycle.
module cpu_sequencer #(
  parameter int unsigned PC_W       = 6,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  cpu_sequencer_if.master bus
);
  localparam int unsigned MAX_LAT = (ALU_LAT > MEM_RD_LAT) ? ALU_LAT : MEM_RD_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] ALU_WAIT = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MEM_WAIT = CNT_W'(MEM_RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALUW, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      mem_op_q, mem_op_d;
  logic            fetch_en_q, fetch_en_d;
  logic            alu_en_q, alu_en_d;
  logic            mem_we_q, mem_we_d;
  logic            rf_we_q, rf_we_d;
  logic            rf_waddr_sel_q, rf_waddr_sel_d;
  logic [1:0]      rf_wsrc_q, rf_wsrc_d;
  logic            opb_imm_q, opb_imm_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic            retired_q, retired_d;
  logic            illegal_q, illegal_d;
  logic            retire, jump, halt_go;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cnt_d          = cnt_q;
    mem_op_d       = mem_op_q;
    alu_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    rf_we_d        = 1'b0;
    illegal_d      = 1'b0;
    rf_waddr_sel_d = rf_waddr_sel_q;
    rf_wsrc_d      = rf_wsrc_q;
    opb_imm_d      = opb_imm_q;
    retire         = 1'b0;
    jump           = 1'b0;
    halt_go        = 1'b0;

    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        mem_op_d       = bus.mem_op;
        rf_waddr_sel_d = 1'b0;
        opb_imm_d      = 1'b0;
        case (bus.flag)
          2'd0: begin
            retire = 1'b1;
            if (bus.oper == 4'h1)      jump = 1'b1;
            else if (bus.oper == 4'hF) halt_go = 1'b1;
            else if (bus.oper != 4'h0) illegal_d = 1'b1;
          end
          2'd1: begin
            if (bus.oper >= 4'h1 && bus.oper <= 4'hC) begin
              alu_en_d       = 1'b1;
              opb_imm_d      = bus.oper inside {4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC};
              rf_waddr_sel_d = (bus.oper == 4'hA);
              rf_wsrc_d      = 2'd0;
              cnt_d          = ALU_WAIT;
              state_d        = S_ALUW;
            end else begin
              illegal_d = 1'b1;
              retire    = 1'b1;
            end
          end
          2'd2: begin
            if (bus.oper == 4'h2 || bus.oper == 4'h3) begin
              rf_wsrc_d = (bus.oper == 4'h2) ? 2'd1 : 2'd2;
              rf_we_d   = 1'b1;
              state_d   = S_WB;
            end else begin
              illegal_d = 1'b1;
              retire    = 1'b1;
            end
          end
          default: begin
            if (bus.mem_op == 2'd0) begin
              illegal_d = 1'b1;
              retire    = 1'b1;
            end else begin
              rf_wsrc_d = 2'd3;
              mem_we_d  = (bus.mem_op != 2'd1);
              cnt_d     = MEM_WAIT;
              state_d   = S_MEM;
            end
          end
        endcase
      end
      S_ALUW: begin
        if (cnt_q == '0) begin
          rf_we_d = 1'b1;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MEM: begin
        // stores finish after their single mem_we cycle; loads wait for data_out
        if (mem_op_q != 2'd1) begin
          retire = 1'b1;
        end else if (cnt_q == '0) begin
          rf_we_d = 1'b1;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WB:     retire = 1'b1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    retired_d = retire;
    if (retire) begin
      pc_d           = jump ? bus.jmp_tgt : pc_q + PC_W'(1);
      rf_waddr_sel_d = 1'b0;
      rf_wsrc_d      = 2'd0;
      opb_imm_d      = 1'b0;
      if (halt_go)      state_d = S_HALT;
      else if (bus.run) state_d = S_FETCH;
      else              state_d = S_IDLE;
    end

    fetch_en_d = (state_d == S_FETCH);
    busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= PC_W'(RESET_PC);
      cnt_q          <= '0;
      mem_op_q       <= '0;
      fetch_en_q     <= 1'b0;
      alu_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_sel_q <= 1'b0;
      rf_wsrc_q      <= '0;
      opb_imm_q      <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
      retired_q      <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      cnt_q          <= cnt_d;
      mem_op_q       <= mem_op_d;
      fetch_en_q     <= fetch_en_d;
      alu_en_q       <= alu_en_d;
      mem_we_q       <= mem_we_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_sel_q <= rf_waddr_sel_d;
      rf_wsrc_q      <= rf_wsrc_d;
      opb_imm_q      <= opb_imm_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
      retired_q      <= retired_d;
      illegal_q      <= illegal_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.fetch_en     = fetch_en_q;
  assign bus.alu_en       = alu_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr_sel = rf_waddr_sel_q;
  assign bus.rf_wsrc      = rf_wsrc_q;
  assign bus.opb_imm      = opb_imm_q;
  assign bus.busy         = busy_q;
  assign bus.halted       = halted_q;
  assign bus.retired      = retired_q;
  assign bus.illegal      = illegal_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: the bench plays instr_mem + decoder from a
// small program table indexed by pc and checks per-instruction strobe timing.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [1:0] p_flag [64];
  logic [3:0] p_oper [64];
  logic [1:0] p_mop  [64];

  typedef struct {
    int lat; int alu_at; int we_at; int mwe_at; int wsrc;
    int wsel; int imm; int ill; int ret; int nxt_pc;
  } obs_t;

  cpu_sequencer_if #(.PC_W(6)) bus ();

  assign bus.flag    = p_flag[bus.pc];
  assign bus.oper    = p_oper[bus.pc];
  assign bus.mem_op  = p_mop[bus.pc];
  assign bus.jmp_tgt = 6'h2A;

  cpu_sequencer #(.PC_W(6), .RESET_PC(0), .ALU_LAT(1), .MEM_RD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ins(input int a, input int f, input int o, input int m);
    p_flag[a] = 2'(f);
    p_oper[a] = 4'(o);
    p_mop[a]  = 2'(m);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) set_ins(i, 0, 0, 0);
  endtask

  task automatic wait_fetch(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.fetch_en) return;
    end
    check({tag, ".fetch_timeout"}, 0, 1);
  endtask

  // Starts at a negedge showing fetch_en; runs to the next fetch, HALT or IDLE.
  task automatic observe(output obs_t o);
    o = '{-1, -1, -1, -1, -1, -1, -1, 0, 0, -1};
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.alu_en) begin o.alu_at = c; o.imm = int'(bus.opb_imm); end
      if (bus.rf_we) begin
        o.we_at = c; o.wsrc = int'(bus.rf_wsrc); o.wsel = int'(bus.rf_waddr_sel);
      end
      if (bus.mem_we) o.mwe_at = c;
      if (bus.illegal) o.ill = 1;
      if (bus.retired) o.ret++;
      if (bus.fetch_en || bus.halted || !bus.busy) begin
        o.lat = c; o.nxt_pc = int'(bus.pc);
        return;
      end
    end
  endtask

  task automatic check_obs(input string tag, input obs_t o, input obs_t e);
    check({tag, ".lat"},    o.lat,    e.lat);
    check({tag, ".alu_at"}, o.alu_at, e.alu_at);
    check({tag, ".we_at"},  o.we_at,  e.we_at);
    check({tag, ".mwe_at"}, o.mwe_at, e.mwe_at);
    check({tag, ".wsrc"},   o.wsrc,   e.wsrc);
    check({tag, ".wsel"},   o.wsel,   e.wsel);
    check({tag, ".imm"},    o.imm,    e.imm);
    check({tag, ".ill"},    o.ill,    e.ill);
    check({tag, ".ret"},    o.ret,    e.ret);
    check({tag, ".nxt_pc"}, o.nxt_pc, e.nxt_pc);
  endtask

  obs_t o;
  int   cnt;

  initial begin
    rst_n   = 1'b0;
    bus.run = 1'b0;
    clear_prog();

    // Reset state and NOP stream with pc wrap
    repeat (3) @(negedge clk);
    check("rst.pc", int'(bus.pc), 0);
    check("rst.strobes", int'({bus.fetch_en, bus.alu_en, bus.mem_we, bus.rf_we,
                               bus.retired, bus.illegal}), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.halted", int'(bus.halted), 0);
    rst_n   = 1'b1;
    bus.run = 1'b1;
    wait_fetch("t1");
    check("t1.first_pc", int'(bus.pc), 0);
    observe(o); check_obs("t1.nop0", o, '{3, -1, -1, -1, -1, -1, -1, 0, 1, 1});
    observe(o); check_obs("t1.nop1", o, '{3, -1, -1, -1, -1, -1, -1, 0, 1, 2});
    for (int i = 0; i < 70 && bus.pc != 6'd63; i++) observe(o);
    check("t1.pc63", int'(bus.pc), 63);
    observe(o); check_obs("t1.wrap", o, '{3, -1, -1, -1, -1, -1, -1, 0, 1, 0});

    // Mixed program: ALU, load, store, moves, illegal, JMP, HALT
    @(negedge clk);
    rst_n = 1'b0;
    clear_prog();
    set_ins(4, 1, 1, 0);    set_ins(5, 3, 0, 1);    set_ins(6, 3, 0, 3);
    set_ins(7, 2, 3, 0);    set_ins(8, 1, 6, 0);    set_ins(9, 1, 10, 0);
    set_ins(10, 1, 15, 0);  set_ins(11, 2, 2, 0);   set_ins(12, 0, 1, 0);
    set_ins(42, 0, 15, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fetch("t2");
    check("t2.first_pc", int'(bus.pc), 0);
    for (int i = 0; i < 4; i++) observe(o);
    check("t2.pc4", int'(bus.pc), 4);
    observe(o); check_obs("t2.alu_add",  o, '{5, 3, 4, -1, 0, 0, 0, 0, 1, 5});
    observe(o); check_obs("t3.load",     o, '{5, -1, 4, -1, 3, 0, -1, 0, 1, 6});
    observe(o); check_obs("t3.st_imm",   o, '{4, -1, -1, 3, -1, -1, -1, 0, 1, 7});
    observe(o); check_obs("mv_imm",      o, '{4, -1, 3, -1, 2, 0, -1, 0, 1, 8});
    observe(o); check_obs("alu_opbimm",  o, '{5, 3, 4, -1, 0, 0, 1, 0, 1, 9});
    observe(o); check_obs("alu_wselb",   o, '{5, 3, 4, -1, 0, 1, 0, 0, 1, 10});
    observe(o); check_obs("t6.illegal",  o, '{3, -1, -1, -1, -1, -1, -1, 1, 1, 11});
    observe(o); check_obs("mv_reg",      o, '{4, -1, 3, -1, 1, 0, -1, 0, 1, 12});
    observe(o); check_obs("t4.jmp",      o, '{3, -1, -1, -1, -1, -1, -1, 0, 1, 42});
    observe(o); check_obs("t4.halt",     o, '{3, -1, -1, -1, -1, -1, -1, 0, 1, 43});
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.fetch_en || bus.rf_we || bus.alu_en || bus.mem_we) cnt++;
    end
    check("t4.halt_strobes", cnt, 0);
    check("t4.halted", int'(bus.halted), 1);
    check("t4.halt_busy", int'(bus.busy), 0);
    check("t4.halt_pc", int'(bus.pc), 43);

    // run dropped mid-ALU, resume, reset in ALUW, illegal ALU op
    @(negedge clk);
    rst_n = 1'b0;
    clear_prog();
    set_ins(0, 1, 1, 0); set_ins(1, 1, 1, 0); set_ins(2, 1, 15, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fetch("t5");
    bus.run = 1'b0;
    observe(o); check_obs("t5.stop", o, '{5, 3, 4, -1, 0, 0, 0, 0, 1, 1});
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.fetch_en || bus.busy) cnt++;
    end
    check("t5.idle_quiet", cnt, 0);
    bus.run = 1'b1;
    wait_fetch("t5r");
    check("t5.resume_pc", int'(bus.pc), 1);
    repeat (3) @(negedge clk);
    check("t6.in_aluw", int'(bus.alu_en), 1);
    rst_n = 1'b0;
    #1;
    check("t6.rst_alu_en", int'(bus.alu_en), 0);
    check("t6.rst_busy", int'(bus.busy), 0);
    check("t6.rst_pc", int'(bus.pc), 0);
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rf_we || bus.mem_we) cnt++;
    end
    check("t6.no_rf_we", cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fetch("t6");
    check("t6.restart_pc", int'(bus.pc), 0);
    observe(o); check_obs("t6.alu0", o, '{5, 3, 4, -1, 0, 0, 0, 0, 1, 1});
    observe(o); check_obs("t6.alu1", o, '{5, 3, 4, -1, 0, 0, 0, 0, 1, 2});
    observe(o); check_obs("t6.ill_alu", o, '{3, -1, -1, -1, -1, -1, -1, 1, 1, 3});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
